instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch FSM (IDLE/REQ/WAIT/LOAD) with PC and redirect.
//            Optional macro FETCH_TIMEOUT_EN adds a 16-cycle WAIT timeout.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        ir_w,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pend_target;
    logic        r_pend_valid;
    logic [31:0] w_target;
    logic        w_capture;
    logic        w_timeout;
    logic        w_unused;

    assign w_target  = {pc_target[31:2], 2'b00};
    assign w_unused  = &{1'b0, pc_target[1:0]};
    assign w_capture = ((r_state == ST_REQ) || (r_state == ST_WAIT)) && mem_ready;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] r_wait_cnt;
    logic       r_fault;

    // Sixteenth consecutive not-ready WAIT cycle aborts the fetch.
    assign w_timeout = (r_state == ST_WAIT) && !mem_ready && (r_wait_cnt == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
            r_fault    <= 1'b0;
        end else begin
            if ((r_state != ST_REQ) && (w_state_nxt == ST_REQ))
                r_wait_cnt <= 4'd0;
            else if ((r_state == ST_WAIT) && !mem_ready)
                r_wait_cnt <= r_wait_cnt + 4'd1;
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (fetch_en) w_state_nxt = ST_REQ;
            ST_REQ:  w_state_nxt = mem_ready ? ST_LOAD : ST_WAIT;
            ST_WAIT: begin
                if (mem_ready)
                    w_state_nxt = ST_LOAD;
                else if (w_timeout)
                    w_state_nxt = ST_IDLE;
            end
            ST_LOAD: w_state_nxt = fetch_en ? ST_REQ : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Redirect priority in LOAD: live pc_load, then pending target, then pc+4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= 32'd0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_load)
                        r_pc <= w_target;
                end
                ST_REQ, ST_WAIT: begin
                    if (w_timeout) begin
                        r_pend_valid <= 1'b0;
                    end else if (pc_load) begin
                        r_pend_valid  <= 1'b1;
                        r_pend_target <= w_target;
                    end
                end
                ST_LOAD: begin
                    if (pc_load)
                        r_pc <= w_target;
                    else if (r_pend_valid)
                        r_pc <= r_pend_target;
                    else
                        r_pc <= r_pc + 32'd4;
                    r_pend_valid <= 1'b0;
                end
                default: r_pend_valid <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_instr <= 32'd0;
        else if (w_capture)
            r_instr <= mem_rdata;
    end

    assign mem_rd      = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign ir_w        = (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);
    assign pc          = r_pc;
    assign mem_addr    = r_pc;
    assign instruction = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit; monitor checks each ir_w.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        ir_w;
    logic [31:0] pc;
    logic        busy;
    logic        fault;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t q_exp[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_pushed = 0;
    int   n_pulses = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .ir_w        (ir_w),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] addr);
        exp_t e;
        e.instr = instr;
        e.addr  = addr;
        q_exp.push_back(e);
        n_pushed++;
    endtask

    // Monitor: every ir_w pulse must match the oldest expected fetch.
    always @(negedge clk) begin
        if (!reset && ir_w) begin
            n_pulses++;
            if (q_exp.size() == 0) begin
                chk("unexpected_ir_w", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("sb_instruction", instruction, e.instr);
                chk("sb_fetch_addr", mem_addr, e.addr);
            end
        end
    end

    initial begin
        int rd_cnt;
        reset     = 1'b1;
        fetch_en  = 1'b0;
        pc_load   = 1'b0;
        pc_target = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_flags", {28'd0, ir_w, mem_rd, busy, fault}, 32'd0);
        reset = 1'b0;

        // Single fetch, zero-wait memory
        fetch_en  = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0030_0020;
        push(32'h0030_0020, 32'h0);
        tick();
        fetch_en = 1'b0;
        chk("t1_mem_addr", mem_addr, 32'h0);
        chk("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        chk("t1_ir_w", {31'd0, ir_w}, 32'd1);
        tick();
        chk("t1_pc", pc, 32'h4);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Back-to-back fetches from address 0
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        fetch_en  = 1'b1;
        mem_rdata = 32'h1000_0030;
        push(32'h1000_0030, 32'h0);
        push(32'h1000_0030, 32'h4);
        push(32'h1000_0030, 32'h8);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_ir_w_cadence", {31'd0, ir_w}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        fetch_en = 1'b0;
        tick();
        chk("t2_pc", pc, 32'hC);

        // Five not-ready cycles then ready
        fetch_en  = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5_0001;
        push(32'hA5A5_0001, 32'hC);
        tick();
        fetch_en = 1'b0;
        rd_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) mem_ready = 1'b1;
            if (mem_rd) rd_cnt++;
            tick();
        end
        chk("t3_mem_rd_cycles", rd_cnt, 32'd6);
        chk("t3_ir_w", {31'd0, ir_w}, 32'd1);
        mem_ready = 1'b0;
        tick();
        chk("t3_pc", pc, 32'h10);

        // Redirect during WAIT overrides pc+4
        fetch_en  = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        push(32'h0BAD_F00D, 32'h10);
        tick();
        fetch_en = 1'b0;
        tick();
        pc_load   = 1'b1;
        pc_target = 32'h0000_0043;
        tick();
        pc_load   = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("t4_pc_in_load", pc, 32'h10);
        mem_ready = 1'b0;
        tick();
        chk("t4_pc_redirect", pc, 32'h40);

        // Asynchronous reset mid-fetch abandons the fetch
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t5_async_busy", {31'd0, busy}, 32'd0);
        chk("t5_async_pc", pc, 32'd0);
        tick();
        reset     = 1'b0;
        fetch_en  = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        push(32'h1234_5678, 32'h0);
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        chk("t5_pc_after", pc, 32'h4);

        // PC wraparound
        pc_load   = 1'b1;
        pc_target = 32'hFFFF_FFFE;
        tick();
        pc_load = 1'b0;
        chk("t6_pc_load_idle", pc, 32'hFFFF_FFFC);
        fetch_en  = 1'b1;
        mem_rdata = 32'hCAFE_0000;
        push(32'hCAFE_0000, 32'hFFFF_FFFC);
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        chk("t6_pc_wrap", pc, 32'h0);

        // Memory never ready
        mem_ready = 1'b0;
        fetch_en  = 1'b1;
        tick();
        fetch_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (16) tick();
        chk("t7_busy_before_timeout", {31'd0, busy}, 32'd1);
        tick();
        chk("t7_timeout_idle", {31'd0, busy}, 32'd0);
        chk("t7_fault", {31'd0, fault}, 32'd1);
        chk("t7_pc_unchanged", pc, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_fault_cleared", {31'd0, fault}, 32'd0);
`else
        repeat (20) tick();
        chk("t7_still_waiting", {31'd0, busy}, 32'd1);
        chk("t7_no_fault", {31'd0, fault}, 32'd0);
        mem_rdata = 32'h7777_0007;
        mem_ready = 1'b1;
        push(32'h7777_0007, 32'h0);
        tick();
        mem_ready = 1'b0;
        tick();
        chk("t7_pc_after", pc, 32'h4);
`endif
        tick();
        chk("pulse_count", n_pulses, n_pushed);
        chk("queue_drained", q_exp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
